// File: rtl/mem_4_3_bist.sv
// March C- BIST controller for the 4x3 mem_4_3 macro: drives the macro pins, checks every read, reports pass/fail.
// Optional first-failure log (fail_addr/fail_exp/fail_act/fail_elem) is compiled in with MEM_BIST_FAIL_LOG_EN.
module mem_4_3_bist #(
    parameter int                DATA_W = 3,
    parameter int                ADDR_W = 2,
    parameter logic [DATA_W-1:0] BG     = 3'b000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [DATA_W-1:0] mem_i,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_cs,
    output logic              mem_rd,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_o
`ifdef MEM_BIST_FAIL_LOG_EN
    ,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act,
    output logic [2:0]        fail_elem
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d, elem_n;
    logic [ADDR_W-1:0] addr_q, addr_d, end_addr;
    logic              rd_q, rd_d;
    logic              busy_d, done_d, fail_d;
    logic [DATA_W-1:0] mem_i_d;
    logic [ADDR_W-1:0] mem_a_d;
    logic              mem_cs_d, mem_rd_d, mem_oe_d;
    logic              mismatch, last;
`ifdef MEM_BIST_FAIL_LOG_EN
    logic [ADDR_W-1:0] fail_addr_d;
    logic [DATA_W-1:0] fail_exp_d, fail_act_d;
    logic [2:0]        fail_elem_d;
`endif

    // Elements 2 and 4 read the complement; 1 and 3 write it; 3 and 4 walk downwards.
    function automatic logic [DATA_W-1:0] read_pat(input logic [2:0] e);
        return (e == 3'd2 || e == 3'd4) ? ~BG : BG;
    endfunction

    function automatic logic [DATA_W-1:0] write_pat(input logic [2:0] e);
        return (e == 3'd1 || e == 3'd3) ? ~BG : BG;
    endfunction

    function automatic logic is_down(input logic [2:0] e);
        return (e == 3'd3 || e == 3'd4);
    endfunction

    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        addr_d   = addr_q;
        rd_d     = rd_q;
        busy_d   = busy;
        done_d   = done;
        fail_d   = fail;
        mem_i_d  = '0;
        mem_a_d  = '0;
        mem_cs_d = 1'b0;
        mem_rd_d = 1'b1;
        mem_oe_d = 1'b0;
        mismatch = 1'b0;
        last     = 1'b0;
        elem_n   = 3'(elem_q + 3'd1);
        end_addr = is_down(elem_q) ? '0 : '1;
`ifdef MEM_BIST_FAIL_LOG_EN
        fail_addr_d = fail_addr;
        fail_exp_d  = fail_exp;
        fail_act_d  = fail_act;
        fail_elem_d = fail_elem;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    elem_d  = 3'd0;
                    addr_d  = '0;
                    rd_d    = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
`ifdef MEM_BIST_FAIL_LOG_EN
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_act_d  = '0;
                    fail_elem_d = '0;
`endif
                end
            end
            RUN: begin
                mismatch = rd_q && (mem_o !== read_pat(elem_q));
                if (mismatch) begin
                    fail_d = 1'b1;
`ifdef MEM_BIST_FAIL_LOG_EN
                    if (!fail) begin
                        fail_addr_d = addr_q;
                        fail_exp_d  = read_pat(elem_q);
                        fail_act_d  = mem_o;
                        fail_elem_d = elem_q;
                    end
`endif
                end
                // Read-then-write elements stay on the address for the write half.
                if (rd_q && elem_q != 3'd5) begin
                    rd_d = 1'b0;
                end else if (addr_q == end_addr) begin
                    if (elem_q == 3'd5) begin
                        last = 1'b1;
                    end else begin
                        elem_d = elem_n;
                        addr_d = is_down(elem_n) ? '1 : '0;
                        rd_d   = 1'b1;
                    end
                end else begin
                    addr_d = is_down(elem_q) ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
                    rd_d   = (elem_q != 3'd0);
                end
                if (last) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == RUN) begin
            mem_cs_d = 1'b1;
            mem_a_d  = addr_d;
            mem_rd_d = rd_d;
            mem_oe_d = rd_d;
            mem_i_d  = rd_d ? '0 : write_pat(elem_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            elem_q  <= 3'd0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fail    <= 1'b0;
            mem_i   <= '0;
            mem_a   <= '0;
            mem_cs  <= 1'b0;
            mem_rd  <= 1'b1;
            mem_oe  <= 1'b0;
`ifdef MEM_BIST_FAIL_LOG_EN
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
            fail_elem <= '0;
`endif
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            busy    <= busy_d;
            done    <= done_d;
            fail    <= fail_d;
            mem_i   <= mem_i_d;
            mem_a   <= mem_a_d;
            mem_cs  <= mem_cs_d;
            mem_rd  <= mem_rd_d;
            mem_oe  <= mem_oe_d;
`ifdef MEM_BIST_FAIL_LOG_EN
            fail_addr <= fail_addr_d;
            fail_exp  <= fail_exp_d;
            fail_act  <= fail_act_d;
            fail_elem <= fail_elem_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_4_3_bist.sv
// Directed bench for mem_4_3_bist with a behavioural 4x3 macro that can inject a stuck-at or floating output.
module tb_mem_4_3_bist;

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic       busy, done, fail;
    logic [2:0] mem_i;
    logic [1:0] mem_a;
    logic       mem_cs, mem_rd, mem_oe;
    wire  [2:0] mem_o;
`ifdef MEM_BIST_FAIL_LOG_EN
    logic [1:0] fail_addr;
    logic [2:0] fail_exp, fail_act, fail_elem;
`endif

    int         fault;
    logic [2:0] memArr [4];
    logic [2:0] memRead;

    int         nChecks = 0;
    int         nBad = 0;
    int         busyCnt, csCnt, wrCnt, rdCnt;
    logic       finished, failAtStart;
    logic       opRd [64];
    logic [1:0] opA  [64];
    logic [2:0] opI  [64];
    logic [2:0] opO  [64];

    mem_4_3_bist dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .fail(fail),
        .mem_i(mem_i), .mem_a(mem_a), .mem_cs(mem_cs),
        .mem_rd(mem_rd), .mem_oe(mem_oe), .mem_o(mem_o)
`ifdef MEM_BIST_FAIL_LOG_EN
        , .fail_addr(fail_addr), .fail_exp(fail_exp),
        .fail_act(fail_act), .fail_elem(fail_elem)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural macro: writes on the closing edge, reads combinationally; fault 1 sticks bit 1 low.
    always @(posedge clk) if (mem_cs && !mem_rd) memArr[mem_a] <= mem_i;
    assign memRead = (fault == 1) ? (memArr[mem_a] & 3'b101) : memArr[mem_a];
    assign mem_o   = (fault == 2) ? 3'bzzz : memRead;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_fail"}, fail, 0);
        checkOutput({tag, "_cs"}, mem_cs, 0);
        checkOutput({tag, "_rd"}, mem_rd, 1);
        checkOutput({tag, "_oe"}, mem_oe, 0);
        checkOutput({tag, "_a"}, mem_a, 0);
        checkOutput({tag, "_i"}, mem_i, 0);
    endtask

    // Pulses start, then traces every busy cycle at the negedge until done; restartAt re-pulses start mid-run.
    task automatic applyStimulus(input int restartAt);
        busyCnt  = 0;
        csCnt    = 0;
        wrCnt    = 0;
        rdCnt    = 0;
        finished = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        failAtStart = fail;
        for (int cyc = 1; cyc <= 100 && !finished; cyc++) begin
            if (busy) begin
                busyCnt++;
                if (mem_cs) csCnt++;
                if (mem_cs && !mem_rd) wrCnt++;
                if (mem_cs && mem_rd && mem_oe) rdCnt++;
                if (busyCnt < 64) begin
                    opRd[busyCnt] = mem_rd;
                    opA[busyCnt]  = mem_a;
                    opI[busyCnt]  = mem_i;
                    opO[busyCnt]  = mem_o;
                end
            end else if (done) begin
                finished = 1'b1;
            end
            if (!finished) begin
                start = (cyc == restartAt);
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!finished) checkOutput("run_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        fault = 0;

        // Asynchronous reset between clock edges
        #12 rst_n = 1'b0;
        #1 checkIdle("reset");
        @(negedge clk) rst_n = 1'b1;

        // Clean run: operation mix and ordering
        applyStimulus(0);
        checkOutput("good_busy_cycles", busyCnt, 40);
        checkOutput("good_cs_cycles", csCnt, 40);
        checkOutput("good_writes", wrCnt, 20);
        checkOutput("good_reads", rdCnt, 20);
        checkOutput("good_done", done, 1);
        checkOutput("good_fail", fail, 0);
        checkOutput("good_end_cs", mem_cs, 0);
        checkOutput("good_end_rd", mem_rd, 1);
        checkOutput("op1_write", opRd[1], 0);
        checkOutput("op1_addr", opA[1], 0);
        checkOutput("op1_data", opI[1], 3'b000);
        checkOutput("op4_addr", opA[4], 3);
        checkOutput("op5_read", opRd[5], 1);
        checkOutput("op6_data", opI[6], 3'b111);
        checkOutput("op13_read_data", opO[13], 3'b111);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("m3_read%0d_rd", k), opRd[21 + 2 * k], 1);
            checkOutput($sformatf("m3_read%0d_addr", k), opA[21 + 2 * k], 3 - k);
            checkOutput($sformatf("m3_read%0d_data", k), opO[21 + 2 * k], 3'b000);
            checkOutput($sformatf("m3_write%0d_data", k), opI[22 + 2 * k], 3'b111);
        end
        checkOutput("op40_addr", opA[40], 3);
        checkOutput("op40_read", opRd[40], 1);

        // Stuck-at-0 on bit 1 of the macro output
        fault = 1;
        applyStimulus(0);
        checkOutput("stuck_busy_cycles", busyCnt, 40);
        checkOutput("stuck_done", done, 1);
        checkOutput("stuck_fail", fail, 1);
`ifdef MEM_BIST_FAIL_LOG_EN
        checkOutput("stuck_fail_elem", fail_elem, 2);
        checkOutput("stuck_fail_addr", fail_addr, 0);
        checkOutput("stuck_fail_exp", fail_exp, 3'b111);
        checkOutput("stuck_fail_act", fail_act, 3'b101);
`endif

        // start while busy is ignored
        fault = 0;
        applyStimulus(5);
        checkOutput("restart_fail_cleared", failAtStart, 0);
        checkOutput("restart_busy_cycles", busyCnt, 40);
        checkOutput("restart_done", done, 1);
        checkOutput("restart_fail", fail, 0);
`ifdef MEM_BIST_FAIL_LOG_EN
        checkOutput("restart_log_cleared", fail_exp, 0);
`endif

        // Reset partway through a run abandons it
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("abort_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1 checkIdle("abort");
        @(negedge clk) rst_n = 1'b1;
        applyStimulus(0);
        checkOutput("after_abort_busy_cycles", busyCnt, 40);
        checkOutput("after_abort_done", done, 1);
        checkOutput("after_abort_fail", fail, 0);

        // Floating output, then a good macro again
        fault = 2;
        applyStimulus(0);
        checkOutput("float_done", done, 1);
        checkOutput("float_fail", fail, 1);
        fault = 0;
        applyStimulus(0);
        checkOutput("recover_fail_cleared", failAtStart, 0);
        checkOutput("recover_done", done, 1);
        checkOutput("recover_fail", fail, 0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
